// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between if_stage and decode: a DEPTH-entry circular
// buffer of {PC, NPC, IR}, flushed by a taken branch. Optional macro FETCHQ_BYPASS_EN
// forwards a fetch straight to decode when the queue is empty and decode is ready.
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                if_PC_out,
    input  logic [31:0]                if_NPC_out,
    input  logic [31:0]                if_IR_out,
    input  logic                       if_valid_inst_out,
    input  logic                       ex_take_branch_out,
    input  logic                       id_ready,
    output logic                       fetch_stall,
    output logic [31:0]                id_PC_out,
    output logic [31:0]                id_NPC_out,
    output logic [31:0]                id_IR_out,
    output logic                       id_valid_inst_out,
    output logic [$clog2(DEPTH):0]     fq_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   r_pc_mem  [DEPTH];
    logic [31:0]   r_npc_mem [DEPTH];
    logic [31:0]   r_ir_mem  [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

`ifdef FETCHQ_BYPASS_EN
    assign w_bypass = w_empty & if_valid_inst_out & id_ready & ~ex_take_branch_out;
`else
    assign w_bypass = 1'b0;
`endif

    // Push is gated by the registered full flag only, so the stall never
    // depends combinationally on id_ready.
    assign w_push = if_valid_inst_out & ~w_full & ~ex_take_branch_out & ~w_bypass;
    assign w_pop  = ~w_empty & ~ex_take_branch_out & id_ready;

    assign fetch_stall = w_full;
    assign fq_count    = r_count;

    // NOTE: storage carries no reset; an entry is only ever read after it has
    // been written, and leaving it out keeps the array in plain RAM cells.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]  <= if_PC_out;
            r_npc_mem[r_wr_ptr] <= if_NPC_out;
            r_ir_mem[r_wr_ptr]  <= if_IR_out;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || ex_take_branch_out) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        id_valid_inst_out = 1'b0;
        id_PC_out         = '0;
        id_NPC_out        = '0;
        id_IR_out         = NOP_INST;
        if (!ex_take_branch_out) begin
            if (!w_empty) begin
                id_valid_inst_out = 1'b1;
                id_PC_out         = r_pc_mem[r_rd_ptr];
                id_NPC_out        = r_npc_mem[r_rd_ptr];
                id_IR_out         = r_ir_mem[r_rd_ptr];
            end else if (w_bypass) begin
                id_valid_inst_out = 1'b1;
                id_PC_out         = if_PC_out;
                id_NPC_out        = if_NPC_out;
                id_IR_out         = if_IR_out;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model of the fetch queue.
module tb_if_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCHQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] ir;
    } ent_t;

    logic        clk;
    logic        rst;
    logic [31:0] if_PC_out, if_NPC_out, if_IR_out;
    logic        if_valid_inst_out, ex_take_branch_out, id_ready;
    logic        fetch_stall;
    logic [31:0] id_PC_out, id_NPC_out, id_IR_out;
    logic        id_valid_inst_out;
    logic [$clog2(DEPTH):0] fq_count;

    if_fetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst),
        .if_PC_out(if_PC_out), .if_NPC_out(if_NPC_out), .if_IR_out(if_IR_out),
        .if_valid_inst_out(if_valid_inst_out), .ex_take_branch_out(ex_take_branch_out),
        .id_ready(id_ready), .fetch_stall(fetch_stall),
        .id_PC_out(id_PC_out), .id_NPC_out(id_NPC_out), .id_IR_out(id_IR_out),
        .id_valid_inst_out(id_valid_inst_out), .fq_count(fq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    ent_t        q[$];       // reference contents, head at index 0
    logic [31:0] popped[$];  // PCs decode actually accepted

    logic        obs_valid, obs_stall;
    logic [31:0] obs_pc, obs_npc, obs_ir;
    int          obs_count;

    // One clock: drive inputs, compare outputs mid-cycle against the model,
    // then advance the model on the rising edge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                         input logic rdy, input logic br, input logic r);
        logic        ev;
        logic [31:0] epc, enpc, eir;
        bit          byp, do_push, do_pop;
        if_valid_inst_out  = v;
        if_PC_out          = pc;
        if_NPC_out         = pc + 32'd4;
        if_IR_out          = ir;
        id_ready           = rdy;
        ex_take_branch_out = br;
        rst                = r;
        @(negedge clk);
        byp = 1'b0;
        ev = 1'b0; epc = '0; enpc = '0; eir = NOP;
        if (!br) begin
            if (q.size() > 0) begin
                ev = 1'b1; epc = q[0].pc; enpc = q[0].npc; eir = q[0].ir;
            end else if (BYP && v && rdy) begin
                ev = 1'b1; epc = pc; enpc = pc + 32'd4; eir = ir; byp = 1'b1;
            end
        end
        obs_valid = id_valid_inst_out;
        obs_stall = fetch_stall;
        obs_pc    = id_PC_out;
        obs_npc   = id_NPC_out;
        obs_ir    = id_IR_out;
        obs_count = int'(fq_count);
        if (!r) begin
            n_cmp++;
            if (obs_valid !== ev) begin
                n_err++; $display("FAIL valid t=%0t got %b exp %b", $time, obs_valid, ev);
            end
            n_cmp++;
            if (obs_pc !== epc || obs_npc !== enpc || obs_ir !== eir) begin
                n_err++;
                $display("FAIL head t=%0t got pc=%h npc=%h ir=%h exp pc=%h npc=%h ir=%h",
                         $time, obs_pc, obs_npc, obs_ir, epc, enpc, eir);
            end
            n_cmp++;
            if (obs_count !== q.size()) begin
                n_err++; $display("FAIL count t=%0t got %0d exp %0d", $time, obs_count, q.size());
            end
            n_cmp++;
            if (obs_stall !== (q.size() == DEPTH)) begin
                n_err++; $display("FAIL stall t=%0t got %b exp %b", $time, obs_stall, q.size() == DEPTH);
            end
        end
        @(posedge clk);
        if (r || br) begin
            q.delete();
        end else begin
            do_push = v && (q.size() < DEPTH) && !byp;
            do_pop  = ev && rdy && !byp;
            if (ev && rdy) popped.push_back(epc);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{pc: pc, npc: pc + 32'd4, ir: ir});
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        idle(1'b0);
        n_cmp++;
        if (obs_count !== 0 || obs_stall !== 1'b0 || obs_valid !== 1'b0 ||
            obs_ir !== NOP || obs_pc !== 32'h0 || obs_npc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state got cnt=%0d stall=%b v=%b ir=%h pc=%h npc=%h exp 0/0/0/%h/0/0",
                     obs_count, obs_stall, obs_valid, obs_ir, obs_pc, obs_npc, NOP);
        end
    endtask

    task automatic test_push3();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        n_cmp++;
        if (obs_count !== 3 || obs_stall !== 1'b0 || obs_pc !== 32'h0 || obs_ir !== 32'hA000_0000) begin
            n_err++;
            $display("FAIL push3 got cnt=%0d stall=%b pc=%h ir=%h exp 3/0/0/a0000000",
                     obs_count, obs_stall, obs_pc, obs_ir);
        end
    endtask

    task automatic test_fill_stall();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        // Fifth push is offered while full and must be rejected.
        cycle(1'b1, 32'h10, 32'hB000_0004, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs_stall !== 1'b1 || obs_count !== 4) begin
            n_err++; $display("FAIL full_stall got stall=%b cnt=%0d exp 1/4", obs_stall, obs_count);
        end
        idle(1'b1);
        cycle(1'b1, 32'h10, 32'hB000_0004, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs_stall !== 1'b0 || obs_count !== 3) begin
            n_err++; $display("FAIL stall_drop got stall=%b cnt=%0d exp 0/3", obs_stall, obs_count);
        end
        idle(1'b0);
        n_cmp++;
        if (obs_count !== 4 || obs_pc !== 32'h4) begin
            n_err++; $display("FAIL refill got cnt=%0d head=%h exp 4/4", obs_count, obs_pc);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
    endtask

    task automatic test_stream();
        int max_cnt;
        do_reset();
        popped.delete();
        max_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h100 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
            if (obs_count > max_cnt) max_cnt = obs_count;
        end
        for (int i = 0; i < 3; i++) idle(1'b1);
        n_cmp++;
        if (max_cnt > 1) begin
            n_err++; $display("FAIL stream_occupancy got max %0d exp <=1", max_cnt);
        end
        n_cmp++;
        if (popped.size() != 10) begin
            n_err++; $display("FAIL stream_len got %0d exp 10", popped.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (popped[i] !== 32'h100 + 32'(4 * i)) begin
                    n_err++;
                    $display("FAIL stream_order idx %0d got %h exp %h", i, popped[i], 32'h100 + 32'(4 * i));
                    break;
                end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h300 + 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (obs_valid !== 1'b0 || obs_ir !== NOP) begin
            n_err++; $display("FAIL flush_out got v=%b ir=%h exp 0/%h", obs_valid, obs_ir, NOP);
        end
        cycle(1'b1, 32'h200, 32'hE000_0000, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs_count !== 0) begin
            n_err++; $display("FAIL flush_empty got cnt=%0d exp 0", obs_count);
        end
        idle(1'b0);
        n_cmp++;
        if (obs_count !== 1 || obs_pc !== 32'h200) begin
            n_err++; $display("FAIL post_branch got cnt=%0d head=%h exp 1/200", obs_count, obs_pc);
        end
        idle(1'b1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 2; i++) cycle(1'b1, 32'h400 + 32'(4 * i), 32'hF000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        do_reset();
        idle(1'b0);
        n_cmp++;
        if (obs_count !== 0 || obs_ir !== NOP || obs_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_mid got cnt=%0d ir=%h v=%b exp 0/%h/0", obs_count, obs_ir, obs_valid, NOP);
        end
    endtask

    task automatic test_bypass();
        logic exp_v;
        int   exp_cnt;
        exp_v   = BYP;
        exp_cnt = BYP ? 0 : 1;
        do_reset();
        cycle(1'b1, 32'h40, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (obs_valid !== exp_v || (exp_v && obs_pc !== 32'h40)) begin
            n_err++; $display("FAIL bypass_same_cycle got v=%b pc=%h exp v=%b", obs_valid, obs_pc, exp_v);
        end
        idle(1'b0);
        n_cmp++;
        if (obs_count !== exp_cnt) begin
            n_err++; $display("FAIL bypass_count got %0d exp %0d", obs_count, exp_cnt);
        end
        idle(1'b1);
    endtask

    task automatic test_random();
        logic [31:0] pc;
        do_reset();
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(99) < 70, pc, $urandom, $urandom_range(99) < 55,
                  $urandom_range(99) < 5, $urandom_range(99) < 1);
            pc = pc + 32'd4;
        end
    endtask

    initial begin
        rst = 1'b1;
        if_valid_inst_out = 1'b0; ex_take_branch_out = 1'b0; id_ready = 1'b0;
        if_PC_out = '0; if_NPC_out = '0; if_IR_out = '0;
        test_reset();
        test_push3();
        test_fill_stall();
        test_stream();
        test_flush();
        test_reset_mid();
        test_bypass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction fetch queue between `if_stage` and the decode stage. It buffers up to DEPTH fetched instructions with their PC and NPC, so that decode back-pressure does not discard fetched work. It exports a stall to the fetch stage when full. A taken branch from EX flushes all wrong-path contents.

## Interface

Parameters:

- `DEPTH`, 4: number of entries; a power of two, at least 2.
- `NOP_INST`, 32'h0000_0013: value driven on `id_IR_out` whenever no valid instruction is presented.

Ports:

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  system reset; one clock, reset is synchronous and active-high.
- `if_PC_out`  in  32  PC of the incoming instruction.
- `if_NPC_out`  in  32  PC+4 of the incoming instruction.
- `if_IR_out`  in  32  incoming instruction word.
- `if_valid_inst_out`  in  1  incoming entry is valid (push request).
- `ex_take_branch_out`  in  1  taken branch; flush the queue.
- `id_ready`  in  1  decode accepts the head entry this cycle.
- `fetch_stall`  out  1  queue full; the fetch stage must hold its PC.
- `id_PC_out`  out  32  head entry PC.
- `id_NPC_out`  out  32  head entry NPC.
- `id_IR_out`  out  32  head entry instruction.
- `id_valid_inst_out`  out  1  head entry valid (pop offer).
- `fq_count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation

- Storage is a circular buffer of DEPTH entries, each {PC, NPC, IR}.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- `count` is a register of width $clog2(DEPTH)+1.
- full = (count == DEPTH); empty = (count == 0).
- `fetch_stall` = full. It is combinational from the count register only, never from `id_ready`.
- Push occurs when `if_valid_inst_out` & !full & !`ex_take_branch_out`. The entry is written at the write pointer, and the write pointer increments.
- Pop occurs when `id_valid_inst_out` & `id_ready`. The read pointer increments.
- Count update: push & pop → unchanged; push only → +1; pop only → −1.
- No push is accepted while full, even if a pop occurs in the same cycle. The stall is therefore count-based and free of combinational loops.
- Flush: when `ex_take_branch_out` = 1, the next clock edge clears pointers and count to 0.
  - The incoming entry in that cycle is discarded.
  - No pop is counted.
- Flush has priority over push and pop. `rst` has priority over flush.
- Output drive:
  - When not empty and no flush, the outputs show the entry at the read pointer with `id_valid_inst_out` = 1.
  - When empty or `ex_take_branch_out` = 1, `id_valid_inst_out` = 0, `id_IR_out` = NOP_INST, and `id_PC_out` = `id_NPC_out` = 0.
- An invalid input (`if_valid_inst_out` = 0) is never stored.

## Timing

- Reset values (cycle after `rst` sampled high):
  - count = 0, pointers = 0, `fetch_stall` = 0, `fq_count` = 0.
  - `id_valid_inst_out` = 0, `id_IR_out` = NOP_INST, `id_PC_out` = `id_NPC_out` = 0.
- Reset mid-operation discards all contents, with the same result as a flush.
- Latency: an entry pushed at edge N is visible on the outputs in cycle N+1 (without bypass).
- Throughput: one push and one pop per cycle. A steady stream with `id_ready` = 1 keeps count constant.
- Full to stall: the push that makes count = DEPTH raises `fetch_stall` in the following cycle. The stall drops the cycle after the first pop from full.
- Flush in cycle N: outputs are invalid in cycle N, the queue is empty in N+1, and the first post-branch fetch can be pushed in N+1.
- Order is strictly FIFO, across pointer wrap-around, with no gaps.

## Configuration

- Macro: `FETCHQ_BYPASS_EN`.
- Defined: when the queue is empty, `if_valid_inst_out` = 1, `id_ready` = 1 and there is no flush, the input is forwarded combinationally to the `id_*` outputs in the same cycle with `id_valid_inst_out` = 1. The entry is not written, so pointers and count are unchanged. If empty and `id_ready` = 0, the entry is stored normally.
- Undefined: no forwarding; minimum latency is one cycle as above.

## Test plan

- Reset, then push PC 0x0, 0x4, 0x8 with `id_ready` = 0 → `fq_count` = 3, `fetch_stall` = 0, head PC = 0x0, `id_IR_out` = first IR.
- Push 5 entries with `id_ready` = 0, DEPTH = 4 → `fetch_stall` = 1 after the fourth push and the fifth is rejected. Then one pop → stall is 0 the next cycle and the 5th entry can be pushed.
- With `id_ready` = 1, stream 10 entries starting at PC 0x100 → outputs are 0x100…0x124 in order across wrap-around, and `fq_count` stays ≤ 1.
- Fill with 3 entries, assert `ex_take_branch_out` together with a valid push → `id_valid_inst_out` = 0 in that cycle, `fq_count` = 0 next cycle, and the pushed entry never appears.
- Assert `rst` while count = 2 → next cycle `fq_count` = 0, `id_IR_out` = 32'h0000_0013, `id_valid_inst_out` = 0.
- `FETCHQ_BYPASS_EN` defined, empty queue, push PC 0x40 with `id_ready` = 1 → `id_PC_out` = 0x40 and valid in the same cycle, with `fq_count` = 0 afterwards.
